// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT sequencer: state encoding,
// default geometry, bit reversal and the stage-counter width.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UNLOAD = 3'd4
    } state_e;

    localparam int DEF_LOG2N    = 10;
    localparam int DEF_BFLY_LAT = 4;

    function automatic int stage_width(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    localparam int DEF_STAGE_W = stage_width(DEF_LOG2N);

    // Reverses the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Stream, memory-address and butterfly-control bundle of the FFT sequencer.
// FFT_SEQ_INVERSE_EN adds the inverse request and the twiddle-conjugate flag.
interface fft_seq_ctrl_if
    import fft_seq_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
);
    localparam int STAGE_W = stage_width(LOG2N);

    logic               start;
    logic               ready;
    logic               in_valid;
    logic               in_ready;
    logic               load_we;
    logic [LOG2N-1:0]   load_addr;
    logic               rd_en;
    logic [LOG2N-1:0]   rd_addr_a;
    logic [LOG2N-1:0]   rd_addr_b;
    logic [LOG2N-2:0]   tw_addr;
    logic               wr_en;
    logic [LOG2N-1:0]   wr_addr_a;
    logic [LOG2N-1:0]   wr_addr_b;
    logic [STAGE_W-1:0] stage;
    logic               out_valid;
    logic               out_ready;
    logic [LOG2N-1:0]   out_addr;
    logic               out_last;
    logic               done;
`ifdef FFT_SEQ_INVERSE_EN
    logic               inverse;
    logic               tw_conj;
`endif

    modport master (
        input  start, in_valid, out_ready,
`ifdef FFT_SEQ_INVERSE_EN
        input  inverse,
        output tw_conj,
`endif
        output ready, in_ready, load_we, load_addr, rd_en, rd_addr_a, rd_addr_b,
        output tw_addr, wr_en, wr_addr_a, wr_addr_b, stage,
        output out_valid, out_addr, out_last, done
    );

    modport slave (
        output start, in_valid, out_ready,
`ifdef FFT_SEQ_INVERSE_EN
        output inverse,
        input  tw_conj,
`endif
        input  ready, in_ready, load_we, load_addr, rd_en, rd_addr_a, rd_addr_b,
        input  tw_addr, wr_en, wr_addr_a, wr_addr_b, stage,
        input  out_valid, out_addr, out_last, done
    );

endinterface

// File: rtl/fft_seq_wb_delay.sv
// Enable-gated shift register that turns butterfly read issues into write-backs
// DEPTH enabled cycles later; clr empties the valid chain only.
module fft_seq_wb_delay #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_a,
    input  logic [ADDR_W-1:0] in_b,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_a,
    output logic [ADDR_W-1:0] out_b
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] a_q [DEPTH];
    logic [ADDR_W-1:0] a_d [DEPTH];
    logic [ADDR_W-1:0] b_q [DEPTH];
    logic [ADDR_W-1:0] b_d [DEPTH];

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        if (en) begin
            vld_d[0] = in_vld;
            a_d[0]   = in_a;
            b_d[0]   = in_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                a_d[i]   = a_q[i-1];
                b_d[i]   = b_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Addresses are qualified by the valid chain and need no clear.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_a   = a_q[DEPTH-1];
    assign out_b   = b_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the in-place radix-2 DIT FFT: bit-reversed load, per-stage
// butterfly issue with delayed write-back, natural-order unload. Option: FFT_SEQ_INVERSE_EN.
module fft_seq_ctrl
    import fft_seq_pkg::*;
#(
    parameter int LOG2N    = DEF_LOG2N,
    parameter int BFLY_LAT = DEF_BFLY_LAT
) (
    input  logic clock_c,
    input  logic reset,
    input  logic en,
    fft_seq_ctrl_if.master bus
);

    localparam int STAGE_W = stage_width(LOG2N);
    localparam int N       = 1 << LOG2N;
    localparam int DCNT_W  = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

    localparam logic [LOG2N-1:0]   CNT_LAST   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0]   HALF_LAST  = LOG2N'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [DCNT_W-1:0]  DCNT_LAST  = DCNT_W'(BFLY_LAT - 1);

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               done_q, done_d;
    logic               conj_q, conj_d;

    logic ready_c, in_ready_c, load_we_c, rd_en_c, out_valid_c, out_last_c;
    logic wb_vld;

    logic [LOG2N-1:0] span, grp, addr_a, addr_b;
    logic [LOG2N-2:0] pos, tw;

    // Butterfly j = cnt_q: group index above the stage bit, position below it.
    always_comb begin
        span   = LOG2N'(1) << stage_q;
        pos    = (LOG2N-1)'(cnt_q & (span - LOG2N'(1)));
        grp    = cnt_q >> stage_q;
        addr_a = ((grp << stage_q) << 1) | {1'b0, pos};
        addr_b = addr_a + span;
        tw     = pos << (STAGE_LAST - stage_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        dcnt_d      = dcnt_q;
        done_d      = 1'b0;
        conj_d      = conj_q;
        ready_c     = 1'b0;
        in_ready_c  = 1'b0;
        load_we_c   = 1'b0;
        rd_en_c     = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.start && en) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
`ifdef FFT_SEQ_INVERSE_EN
                    conj_d  = bus.inverse;
`endif
                end
            end
            ST_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && en) begin
                    load_we_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            ST_CALC: begin
                rd_en_c = en;
                if (en) begin
                    if (cnt_q == HALF_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    if (dcnt_q == DCNT_LAST) begin
                        dcnt_d = '0;
                        if (stage_q == STAGE_LAST) begin
                            state_d = ST_UNLOAD;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_CALC;
                            stage_d = stage_q + STAGE_W'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
            ST_UNLOAD: begin
                out_valid_c = 1'b1;
                out_last_c  = (cnt_q == CNT_LAST);
                if (bus.out_ready && en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // done is a pure pulse, so it is not held by en.
    always_ff @(posedge clock_c) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            conj_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            conj_q  <= conj_d;
        end
    end

    fft_seq_wb_delay #(
        .DEPTH  (BFLY_LAT),
        .ADDR_W (LOG2N)
    ) u_wb_delay (
        .clk     (clock_c),
        .clr     (reset),
        .en      (en),
        .in_vld  (rd_en_c),
        .in_a    (addr_a),
        .in_b    (addr_b),
        .out_vld (wb_vld),
        .out_a   (bus.wr_addr_a),
        .out_b   (bus.wr_addr_b)
    );

    assign bus.ready     = ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.load_we   = load_we_c;
    assign bus.load_addr = LOG2N'(bitrev(32'(cnt_q), LOG2N));
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr_a = addr_a;
    assign bus.rd_addr_b = addr_b;
    assign bus.tw_addr   = tw;
    assign bus.wr_en     = wb_vld & en;
    assign bus.stage     = stage_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_addr  = cnt_q;
    assign bus.out_last  = out_last_c;
    assign bus.done      = done_q;
`ifdef FFT_SEQ_INVERSE_EN
    assign bus.tw_conj   = conj_q;
`endif

endmodule
